// File: rtl/sp_ram_pkg.sv
// Shared types and parameter legality helpers for the sp_ram_ctrl slice.
package sp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
  endfunction

  function automatic bit data_w_legal(input int unsigned w);
    return (w != 0) && (w % 8 == 0);
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Single-port storage with per-byte write strobes and a one-cycle registered read.
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds between reads so the top can expose it directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Valid/ready front end for sp_ram_array: post-reset clear, request handshake
// and optional second read stage for RD_LAT=2.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned RD_LAT         = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  init_done
);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("sp_ram_ctrl: DATA_W must be a non-zero multiple of 8");
  end
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("sp_ram_ctrl: RD_LAT must be 1 or 2");
  end

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clearing;
  logic                accept;
  logic                rd_fire;
  logic                rd_v1;
  logic                arr_we;
  logic [DATA_W/8-1:0] arr_be;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  // init_done follows the next state, so ready trails the reset release by one
  // cycle when no clear is configured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      rd_v1     <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_done <= (state_d == ST_READY);
      rd_v1     <= rd_fire;
      if (state_q == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_cnt == '1) begin
      state_d = ST_READY;
    end
  end

  always_comb begin
    clearing  = (state_q == ST_CLEAR);
    req_ready = en && (state_q == ST_READY) && init_done;
    accept    = req_valid && req_ready;
    rd_fire   = accept && !req_write;
    arr_we    = clearing || (accept && req_write);
    arr_be    = clearing ? '1      : req_be;
    arr_addr  = clearing ? clr_cnt : req_addr;
    arr_wdata = clearing ? '0      : req_wdata;
  end

  sp_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (rd_fire),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  if (RD_LAT == 2) begin : g_lat2
    logic              rd_v2;
    logic [DATA_W-1:0] rd_d2;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) begin
          rd_d2 <= arr_rdata;
        end
      end
    end

    assign rd_valid = rd_v2;
    assign rd_data  = rd_d2;
  end else begin : g_lat1
    assign rd_valid = rd_v1;
    assign rd_data  = arr_rdata;
  end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Random and directed checks of sp_ram_ctrl (RD_LAT=2 and RD_LAT=1 instances)
// against an array-based reference of the memory and its read timing.
module tb_sp_ram_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;

  logic          ready_a, ready_b;
  logic          rd_valid_a, rd_valid_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          init_a, init_b;

  always #5 clk = ~clk;

  sp_ram_ctrl #(
    .ADDR_W (AW), .DATA_W (DW), .RD_LAT (2), .CLEAR_ON_RESET (1'b1)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .en (en), .req_valid (req_valid),
    .req_ready (ready_a), .req_write (req_write), .req_addr (req_addr),
    .req_wdata (req_wdata), .req_be (req_be), .rd_valid (rd_valid_a),
    .rd_data (rd_data_a), .init_done (init_a)
  );

  sp_ram_ctrl #(
    .ADDR_W (AW), .DATA_W (DW), .RD_LAT (1), .CLEAR_ON_RESET (1'b1)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .en (en), .req_valid (req_valid),
    .req_ready (ready_b), .req_write (req_write), .req_addr (req_addr),
    .req_wdata (req_wdata), .req_be (req_be), .rd_valid (rd_valid_b),
    .rd_data (rd_data_b), .init_done (init_b)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            rel_cnt   = 0;
  bit            ref_ready = 1'b0;
  bit            p2_v      = 1'b0;
  logic [DW-1:0] p2_d      = '0;
  logic [DW-1:0] last_a    = '0;
  logic [DW-1:0] last_b    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, sample at the next falling edge.
  task automatic cyc(input bit rst, input bit e, input bit v, input bit w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    bit            acc;
    bit            rd_now;
    logic [DW-1:0] rd_d;
    rst_n     = !rst;
    en        = e;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = b;
    #1;
    check("req_ready_a", ready_a, ref_ready && e);
    check("req_ready_b", ready_b, ref_ready && e);
    acc    = !rst && ref_ready && e && v;
    rd_now = 1'b0;
    rd_d   = '0;
    @(posedge clk);
    if (rst) begin
      rel_cnt   = 0;
      ref_ready = 1'b0;
      p2_v      = 1'b0;
      last_a    = '0;
      last_b    = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      if (acc && w) begin
        for (int i = 0; i < NB; i++)
          if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      end else if (acc) begin
        rd_now = 1'b1;
        rd_d   = ref_mem[a];
      end
      if (rel_cnt < DEPTH) rel_cnt++;
      ref_ready = (rel_cnt == DEPTH);
    end
    @(negedge clk);
    check("rd_valid_b", rd_valid_b, rd_now);
    if (rd_now) last_b = rd_d;
    check("rd_data_b", rd_data_b, last_b);
    check("rd_valid_a", rd_valid_a, p2_v);
    if (p2_v) last_a = p2_d;
    check("rd_data_a", rd_data_a, last_a);
    p2_v = rd_now;
    p2_d = rd_d;
    check("init_done_a", init_a, ref_ready);
    check("init_done_b", init_b, ref_ready);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, a, $urandom, '1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, a, d, b);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    // Partial clear with requests offered, then reset mid-clear and a full clear.
    for (int i = 0; i < 100; i++) wr(AW'(i), 32'hDEAD_BEEF, '1);
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hFFFF_FFFF, '1);

    rd(8'h00); rd(8'h7F); rd(8'hFF);
    idle(2);
    check("clear_word_ff", rd_data_a, 32'h0);

    wr(8'h05, 32'hAABB_CCDD, 4'b1111);
    wr(8'h05, 32'h1122_3344, 4'b0101);
    rd(8'h05);
    idle(2);
    check("byte_merge", rd_data_a, 32'hAA22_CC44);

    wr(8'h10, 32'h0000_005A, 4'b1111);
    rd(8'h10);
    idle(2);
    check("read_after_write", rd_data_a, 32'h0000_005A);

    wr(8'h01, 32'h0101_0101, '1);
    wr(8'h02, 32'h0202_0202, '1);
    wr(8'h03, 32'h0303_0303, '1);
    rd(8'h01); rd(8'h02); rd(8'h03);
    idle(4);
    check("hold_last", rd_data_a, 32'h0303_0303);

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 32'hFFFF_FFFF, '1);
    rd(8'h10);
    idle(2);
    check("en_gate", rd_data_a, 32'h0000_005A);

    for (int i = 0; i < 600; i++) begin
      cyc(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom,
          NB'($urandom));
    end
    idle(3);

    // Reads in flight across a reset must vanish; the clear then reruns in full.
    rd(8'h03); rd(8'h02);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    idle(DEPTH);
    rd(8'h03);
    idle(2);
    check("post_reset_clear", rd_data_a, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
